// File: rtl/execute_muldiv_seq_if.sv
// Handshake between decode and the iterative mul/div sequencer of the execute stage.
// The slave modport is the sequencer side and the master modport is the decode/bench side.
interface execute_muldiv_seq_if #(
   parameter int LEN_REG     = 16,
   parameter int LEN_OPECODE = 7
);
   logic                   valid_i;
   logic [LEN_OPECODE-1:0] opecode;
   logic [LEN_REG-1:0]     data_rd;
   logic [LEN_REG-1:0]     data_rs;
   logic                   stall_i;
   logic                   stall_o;
   logic                   valid_o;
   logic [LEN_REG-1:0]     data_o;
   logic                   busy;

   modport slave (
      input  valid_i, opecode, data_rd, data_rs, stall_i,
      output stall_o, valid_o, data_o, busy
   );

   modport master (
      output valid_i, opecode, data_rd, data_rs, stall_i,
      input  stall_o, valid_o, data_o, busy
   );
endinterface

// File: rtl/execute_muldiv_seq.sv
// Iterative mul/div sequencer: one bit per cycle, stalls upstream while busy.
// Results are presented with valid_o, and are held while downstream stalls.
module execute_muldiv_seq #(
   parameter int LEN_REG     = 16,
   parameter int LEN_OPECODE = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   execute_muldiv_seq_if.slave  bus
);
   localparam int LEN_CNT = $clog2(LEN_REG);
   localparam logic [LEN_OPECODE-1:0] OP_MUL   = LEN_OPECODE'(7'b000_0010);
   localparam logic [LEN_OPECODE-1:0] OP_DIV   = LEN_OPECODE'(7'b000_0011);
   localparam logic [LEN_CNT-1:0]     CNT_LAST = LEN_CNT'(LEN_REG - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   state_e             state_q, state_d;
   logic [LEN_CNT-1:0] cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               valid_q, valid_d;
   logic [LEN_REG-1:0] data_q, data_d;
   // a: multiplicand (mul) or dividend shifting into quotient (div)
   // b: multiplier shifting right (mul) or constant divisor (div)
   // r: product accumulator (mul) or partial remainder (div)
   logic [LEN_REG-1:0] a_q, a_d;
   logic [LEN_REG-1:0] b_q, b_d;
   logic [LEN_REG-1:0] r_q, r_d;

   logic               is_muldiv_s;
   logic               div_zero_s;
   logic               accept_s;
   logic               last_iter_s;
   logic [LEN_REG-1:0] mul_sum_s;
   logic [LEN_REG:0]   div_diff_s;
   logic [LEN_REG-1:0] step_a_s;
   logic [LEN_REG-1:0] step_b_s;
   logic [LEN_REG-1:0] step_r_s;

   assign is_muldiv_s = bus.valid_i & ((bus.opecode == OP_MUL) | (bus.opecode == OP_DIV));
   assign div_zero_s  = (bus.opecode == OP_DIV) & (bus.data_rs == {LEN_REG{1'b0}});
   assign accept_s    = is_muldiv_s &
                        ((state_q == ST_IDLE) | ((state_q == ST_DONE) & ~bus.stall_i));
   assign last_iter_s = (cnt_q == CNT_LAST);

   assign mul_sum_s  = r_q + a_q;
   // Trial subtraction is one bit wider so its MSB acts as the borrow flag.
   assign div_diff_s = {r_q, a_q[LEN_REG-1]} - {1'b0, b_q};

   // One datapath iteration of the op in flight.
   always_comb begin
      step_a_s = a_q;
      step_b_s = b_q;
      step_r_s = r_q;
      if (is_div_q) begin
         if (!div_diff_s[LEN_REG]) begin
            step_r_s = div_diff_s[LEN_REG-1:0];
            step_a_s = {a_q[LEN_REG-2:0], 1'b1};
         end else begin
            step_r_s = {r_q[LEN_REG-2:0], a_q[LEN_REG-1]};
            step_a_s = {a_q[LEN_REG-2:0], 1'b0};
         end
      end else begin
         if (b_q[0]) begin
            step_r_s = mul_sum_s;
         end else begin
            step_r_s = r_q;
         end
         step_a_s = {a_q[LEN_REG-2:0], 1'b0};
         step_b_s = {1'b0, b_q[LEN_REG-1:1]};
      end
   end

   // Next state, operand capture and result registration.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      a_d      = a_q;
      b_d      = b_q;
      r_d      = r_q;
      valid_d  = valid_q;
      data_d   = data_q;
      if (accept_s) begin
         is_div_d = (bus.opecode == OP_DIV);
         a_d      = bus.data_rd;
         b_d      = bus.data_rs;
         r_d      = {LEN_REG{1'b0}};
         cnt_d    = {LEN_CNT{1'b0}};
         if (div_zero_s) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            data_d  = {LEN_REG{1'b1}};
         end else begin
            state_d = ST_RUN;
            valid_d = 1'b0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
            ST_RUN: begin
               a_d = step_a_s;
               b_d = step_b_s;
               r_d = step_r_s;
               if (last_iter_s) begin
                  state_d = ST_DONE;
                  valid_d = 1'b1;
                  data_d  = is_div_q ? step_a_s : step_r_s;
               end else begin
                  cnt_d = cnt_q + LEN_CNT'(1);
               end
            end
            ST_DONE: begin
               if (!bus.stall_i) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
               end else begin
                  state_d = ST_DONE;
                  valid_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= {LEN_CNT{1'b0}};
         is_div_q <= 1'b0;
         a_q      <= {LEN_REG{1'b0}};
         b_q      <= {LEN_REG{1'b0}};
         r_q      <= {LEN_REG{1'b0}};
         valid_q  <= 1'b0;
         data_q   <= {LEN_REG{1'b0}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         a_q      <= a_d;
         b_q      <= b_d;
         r_q      <= r_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
      end
   end

   // The stall path stays combinational so downstream back-pressure reaches decode in the same cycle.
   assign bus.stall_o = (state_q == ST_RUN) | ((state_q == ST_DONE) & bus.stall_i);
   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.valid_o = valid_q;
   assign bus.data_o  = data_q;
endmodule

// File: tb/tb_execute_muldiv_seq.sv
// Randomised and directed checks of the mul/div sequencer against an arithmetic reference.
// The checks cover reset, latency, stall hold, back-to-back ops and ignored opcodes.
module tb_execute_muldiv_seq;
   localparam int W = 16;
   localparam logic [6:0] OP_ADD = 7'b000_0000;
   localparam logic [6:0] OP_MUL = 7'b000_0010;
   localparam logic [6:0] OP_DIV = 7'b000_0011;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   execute_muldiv_seq_if #(.LEN_REG(W), .LEN_OPECODE(7)) bus ();
   execute_muldiv_seq #(.LEN_REG(W), .LEN_OPECODE(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] model(input logic is_div, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [2*W-1:0] p;
      if (is_div) begin
         if (b == 16'h0000) return 16'hFFFF;
         return a / b;
      end
      p = a * b;
      return p[W-1:0];
   endfunction

   function automatic int model_lat(input logic is_div, input logic [W-1:0] b);
      return (is_div && b == 16'h0000) ? 0 : W;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op with stall_i low, then report the flags seen after the accept edge, the latency and the result.
   task automatic do_op(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2:0] flags, output int lat, output logic [W-1:0] res);
      bus.valid_i = 1'b1;
      bus.opecode = is_div ? OP_DIV : OP_MUL;
      bus.data_rd = a;
      bus.data_rs = b;
      bus.stall_i = 1'b0;
      tick();
      bus.valid_i = 1'b0;
      bus.opecode = OP_ADD;
      bus.data_rd = W'($urandom);
      bus.data_rs = W'($urandom);
      flags = {bus.busy, bus.stall_o, bus.valid_o};
      lat = 0;
      while (bus.valid_o !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      res = bus.data_o;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.valid_i = 1'b0;
      bus.opecode = OP_ADD;
      bus.data_rd = 16'h0000;
      bus.data_rs = 16'h0000;
      bus.stall_i = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid_o); end
      n_checks++;
      if (bus.data_o !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", bus.data_o); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_checks++;
      if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o); end
      rst = 1'b1;
      tick();
      n_checks++;
      if ({bus.busy, bus.valid_o} !== 2'b00) begin
         n_fail++; $display("FAIL reset_release: busy/valid got %b expected 00", {bus.busy, bus.valid_o});
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [4] = '{16'h0007, 16'hFFFF, 16'h0064, 16'h1234};
      logic [W-1:0] vb [4] = '{16'h0006, 16'hFFFF, 16'h0007, 16'h0000};
      logic [W-1:0] vx [4] = '{16'h002A, 16'h0001, 16'h000E, 16'hFFFF};
      logic         vd [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0]   flags;
      logic [2:0]   exp_flags;
      int           lat;
      logic [W-1:0] res;
      for (int i = 0; i < 4; i++) begin
         do_op(vd[i], va[i], vb[i], flags, lat, res);
         exp_flags = (vd[i] && vb[i] == 16'h0000) ? 3'b101 : 3'b110;
         n_checks++;
         if (flags !== exp_flags) begin n_fail++; $display("FAIL dir%0d_accept_flags: got %b expected %b", i, flags, exp_flags); end
         n_checks++;
         if (lat !== model_lat(vd[i], vb[i])) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, model_lat(vd[i], vb[i])); end
         n_checks++;
         if (res !== vx[i]) begin n_fail++; $display("FAIL dir%0d_result: got %h expected %h", i, res, vx[i]); end
         tick();
         n_checks++;
         if ({bus.busy, bus.valid_o, bus.stall_o} !== 3'b000) begin
            n_fail++; $display("FAIL dir%0d_idle_after: busy/valid/stall got %b expected 000", i, {bus.busy, bus.valid_o, bus.stall_o});
         end
      end
   endtask

   task automatic test_ignore();
      logic [6:0] op;
      for (int i = 0; i < 6; i++) begin
         op = (i == 0) ? OP_ADD : 7'($urandom_range(4, 127));
         bus.valid_i = 1'b1;
         bus.opecode = op;
         bus.data_rd = W'($urandom);
         bus.data_rs = W'($urandom);
         tick();
         n_checks++;
         if ({bus.busy, bus.stall_o, bus.valid_o} !== 3'b000) begin
            n_fail++; $display("FAIL ignore_op%h: busy/stall/valid got %b expected 000", op, {bus.busy, bus.stall_o, bus.valid_o});
         end
      end
      bus.valid_i = 1'b0;
   endtask

   task automatic test_stall_hold();
      logic [2:0]   flags;
      int           lat;
      logic [W-1:0] res;
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      do_op(1'b0, a, b, flags, lat, res);
      n_checks++;
      if (res !== model(1'b0, a, b)) begin n_fail++; $display("FAIL stall_first_result: got %h expected %h", res, model(1'b0, a, b)); end
      bus.stall_i = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if ({bus.valid_o, bus.stall_o, bus.busy} !== 3'b111 || bus.data_o !== model(1'b0, a, b)) begin
            n_fail++; $display("FAIL stall_hold%0d: valid/stall/busy %b data %h expected 111 %h",
                               i, {bus.valid_o, bus.stall_o, bus.busy}, bus.data_o, model(1'b0, a, b));
         end
      end
      bus.valid_i = 1'b1;
      bus.opecode = OP_DIV;
      bus.data_rd = 16'h0010;
      bus.data_rs = 16'h0004;
      bus.stall_i = 1'b0;
      #1;
      n_checks++;
      if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL stall_drop_comb: got %b expected 0", bus.stall_o); end
      tick();
      bus.valid_i = 1'b0;
      bus.data_rd = 16'hFFFF;
      bus.data_rs = 16'h0001;
      bus.stall_i = 1'b1;
      n_checks++;
      if ({bus.busy, bus.stall_o, bus.valid_o} !== 3'b110) begin
         n_fail++; $display("FAIL stall_b2b_accept: busy/stall/valid got %b expected 110", {bus.busy, bus.stall_o, bus.valid_o});
      end
      lat = 0;
      while (bus.valid_o !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      n_checks++;
      if (lat !== W) begin n_fail++; $display("FAIL stall_b2b_latency: got %0d expected %0d", lat, W); end
      n_checks++;
      if (bus.data_o !== 16'h0004) begin n_fail++; $display("FAIL stall_b2b_result: got %h expected 0004", bus.data_o); end
      bus.stall_i = 1'b0;
      tick();
      n_checks++;
      if ({bus.busy, bus.valid_o} !== 2'b00) begin n_fail++; $display("FAIL stall_release_idle: got %b expected 00", {bus.busy, bus.valid_o}); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]   flags;
      int           lat;
      logic [W-1:0] res;
      logic         is_div;
      logic [W-1:0] a;
      logic [W-1:0] b;
      for (int i = 0; i < 24; i++) begin
         is_div = 1'($urandom);
         a = W'($urandom);
         b = ($urandom_range(0, 4) == 0) ? 16'h0000 : W'($urandom >> $urandom_range(0, 15));
         do_op(is_div, a, b, flags, lat, res);
         n_checks++;
         if (lat !== model_lat(is_div, b) || res !== model(is_div, a, b)) begin
            n_fail++; $display("FAIL b2b%0d_%s: a=%h b=%h lat %0d res %h expected lat %0d res %h",
                               i, is_div ? "div" : "mul", a, b, lat, res, model_lat(is_div, b), model(is_div, a, b));
         end
         if ($urandom_range(0, 2) == 0) begin
            tick();
         end
      end
      tick();
   endtask

   task automatic test_reset_midrun();
      int seen_valid;
      bus.valid_i = 1'b1;
      bus.opecode = OP_MUL;
      bus.data_rd = 16'h0123;
      bus.data_rs = 16'h0456;
      bus.stall_i = 1'b0;
      tick();
      bus.valid_i = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({bus.valid_o, bus.busy, bus.stall_o} !== 3'b000 || bus.data_o !== 16'h0000) begin
         n_fail++; $display("FAIL midrun_reset: valid/busy/stall %b data %h expected 000 0000",
                            {bus.valid_o, bus.busy, bus.stall_o}, bus.data_o);
      end
      tick();
      rst = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (bus.valid_o !== 1'b0 || bus.busy !== 1'b0) seen_valid++;
      end
      n_checks++;
      if (seen_valid !== 0) begin n_fail++; $display("FAIL midrun_stale_valid: got %0d active cycles expected 0", seen_valid); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore();
      test_stall_hold();
      test_back_to_back();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
